// File: rtl/classify_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// classify_sweep_ctrl_if
// Bundles the control request, the classifier operand/flag pair and the
// sweep result counters for classify_sweep_ctrl.
//
// Optional feature macro: CLASSIFY_BOTH_CNT_EN (adds both_cnt)
//
// Signals:
//   start, abort   : sweep request / terminate request
//   lo, hi         : inclusive operand range captured on an accepted start
//   a_out          : operand driven to the classifier
//   p_in, d_in     : classifier flag results
//   busy, done     : sweep active / one-cycle completion pulse
//   p_cnt, d_cnt   : per-flag operand counts
//   both_cnt       : count of operands raising both flags (optional)
//
// Modports:
//   master : control side plus the classifier (drives requests and flags)
//   slave  : the sweep controller
// ---------------------------------------------------------------------------
interface classify_sweep_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = WIDTH + 1
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] a_out;
    logic             p_in;
    logic             d_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] d_cnt;
`ifdef CLASSIFY_BOTH_CNT_EN
    logic [CNT_W-1:0] both_cnt;
`endif

`ifdef CLASSIFY_BOTH_CNT_EN
    modport master (
        output start, abort, lo, hi, p_in, d_in,
        input  a_out, busy, done, p_cnt, d_cnt, both_cnt
    );

    modport slave (
        input  start, abort, lo, hi, p_in, d_in,
        output a_out, busy, done, p_cnt, d_cnt, both_cnt
    );
`else
    modport master (
        output start, abort, lo, hi, p_in, d_in,
        input  a_out, busy, done, p_cnt, d_cnt
    );

    modport slave (
        input  start, abort, lo, hi, p_in, d_in,
        output a_out, busy, done, p_cnt, d_cnt
    );
`endif

endinterface : classify_sweep_ctrl_if

// File: rtl/classify_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// classify_sweep_ctrl
// Walks a combinational classifier's operand through the inclusive range
// lo..hi (wrapping modulo 2^WIDTH), one operand every two cycles (settle,
// then sample), and counts how many operands raised each classifier flag.
//
// Optional feature macro: CLASSIFY_BOTH_CNT_EN
//   defined   : both_cnt counts operands with p_in && d_in
//   undefined : no both_cnt port or counter
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : classify_sweep_ctrl_if.slave (request, operand, flags, results)
//
// All bus outputs are registered.
// ---------------------------------------------------------------------------
module classify_sweep_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    classify_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_out;
    logic [WIDTH-1:0] w_a_out_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [CNT_W-1:0] r_p_cnt;
    logic [CNT_W-1:0] w_p_cnt_nxt;
    logic [CNT_W-1:0] r_d_cnt;
    logic [CNT_W-1:0] w_d_cnt_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
`ifdef CLASSIFY_BOTH_CNT_EN
    logic [CNT_W-1:0] r_both_cnt;
    logic [CNT_W-1:0] w_both_cnt_nxt;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a_out    <= '0;
            r_hi       <= '0;
            r_p_cnt    <= '0;
            r_d_cnt    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef CLASSIFY_BOTH_CNT_EN
            r_both_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_a_out    <= w_a_out_nxt;
            r_hi       <= w_hi_nxt;
            r_p_cnt    <= w_p_cnt_nxt;
            r_d_cnt    <= w_d_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef CLASSIFY_BOTH_CNT_EN
            r_both_cnt <= w_both_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_a_out_nxt    = r_a_out;
        w_hi_nxt       = r_hi;
        w_p_cnt_nxt    = r_p_cnt;
        w_d_cnt_nxt    = r_d_cnt;
        w_done_nxt     = 1'b0;
`ifdef CLASSIFY_BOTH_CNT_EN
        w_both_cnt_nxt = r_both_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt    = ST_SETTLE;
                    w_a_out_nxt    = bus.lo;
                    w_hi_nxt       = bus.hi;
                    w_p_cnt_nxt    = '0;
                    w_d_cnt_nxt    = '0;
`ifdef CLASSIFY_BOTH_CNT_EN
                    w_both_cnt_nxt = '0;
`endif
                end
            end

            ST_SETTLE: begin
                w_state_nxt = bus.abort ? ST_IDLE : ST_SAMPLE;
            end

            ST_SAMPLE: begin
                // Accumulation happens even when abort coincides with SAMPLE
                w_p_cnt_nxt    = r_p_cnt + CNT_W'(bus.p_in);
                w_d_cnt_nxt    = r_d_cnt + CNT_W'(bus.d_in);
`ifdef CLASSIFY_BOTH_CNT_EN
                w_both_cnt_nxt = r_both_cnt + CNT_W'(bus.p_in & bus.d_in);
`endif
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_a_out == r_hi) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    // Natural WIDTH-bit overflow gives the modulo 2^WIDTH wrap
                    w_a_out_nxt = r_a_out + WIDTH'(1);
                    w_state_nxt = ST_SETTLE;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // busy covers the registered done cycle so it drops one edge after done
        w_busy_nxt = (w_state_nxt != ST_IDLE) || (r_state == ST_DONE);
    end

    assign bus.a_out    = r_a_out;
    assign bus.p_cnt    = r_p_cnt;
    assign bus.d_cnt    = r_d_cnt;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
`ifdef CLASSIFY_BOTH_CNT_EN
    assign bus.both_cnt = r_both_cnt;
`endif

endmodule : classify_sweep_ctrl

// File: tb/tb_classify_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_classify_sweep_ctrl
// Self-checking bench for classify_sweep_ctrl. The classifier is modelled as
// p = operand is prime, d = operand divisible by 3. Directed sweeps come from
// a table; random sweeps are checked against a range-walk reference model.
// ---------------------------------------------------------------------------
module tb_classify_sweep_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned RANGE = 16;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    classify_sweep_ctrl_if #(.WIDTH(WIDTH)) bus ();

    classify_sweep_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int k = 2; k * k <= v; k++) begin
            if (v % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit is_div3(input int v);
        return (v % 3) == 0;
    endfunction

    // Classifier environment driven from the operand bus
    always_comb begin
        bus.p_in = is_prime(int'(bus.a_out));
        bus.d_in = is_div3(int'(bus.a_out));
    end

    typedef struct {
        int lo;
        int hi;
        int p;
        int d;
        int both;
        int lat;
    } vec_t;

    vec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: enumerate operands lo, lo+1, ... hi modulo RANGE
    task automatic model(input int lo, input int hi,
                         output int p, output int d, output int both, output int lat);
        int n;
        int op;
        n = ((hi - lo + RANGE) % RANGE) + 1;
        p = 0; d = 0; both = 0;
        for (int i = 0; i < n; i++) begin
            op = (lo + i) % RANGE;
            p    += int'(is_prime(op));
            d    += int'(is_div3(op));
            both += int'(is_prime(op) && is_div3(op));
        end
        lat = 2 * n + 1;
    endtask

    // One sweep: optional chained start for the next sweep during the done cycle
    task automatic run_sweep(input int lo, input int hi, input int p, input int d,
                             input int both, input int lat, input bit pre,
                             input bit chain, input int clo, input int chi,
                             input bit mid_start, input string tag);
        int  cyc;
        bit  seen;
        if (!pre) begin
            bus.lo    = WIDTH'(lo);
            bus.hi    = WIDTH'(hi);
            bus.start = 1'b1;
        end
        tick();
        bus.start = 1'b0;
        check({tag, " busy_at_start"}, int'(bus.busy), 1);
        check({tag, " a_out_at_start"}, int'(bus.a_out), lo);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 4 * RANGE) begin
            tick();
            cyc++;
            if (mid_start && cyc == 1) begin
                bus.start = 1'b1;
                bus.lo    = WIDTH'(5);
                bus.hi    = WIDTH'(9);
            end else if (mid_start && cyc == 2) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else if (cyc % 2 == 1) begin
                check({tag, " a_out_seq"}, int'(bus.a_out), (lo + (cyc - 1) / 2) % RANGE);
            end
        end
        if (!seen) begin
            check({tag, " done_timeout"}, 0, 1);
            return;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " p_cnt"}, int'(bus.p_cnt), p);
        check({tag, " d_cnt"}, int'(bus.d_cnt), d);
`ifdef CLASSIFY_BOTH_CNT_EN
        check({tag, " both_cnt"}, int'(bus.both_cnt), both);
`endif
        check({tag, " busy_during_done"}, int'(bus.busy), 1);
        if (chain) begin
            bus.lo    = WIDTH'(clo);
            bus.hi    = WIDTH'(chi);
            bus.start = 1'b1;
        end else begin
            tick();
            check({tag, " done_one_cycle"}, int'(bus.done), 0);
            check({tag, " busy_dropped"}, int'(bus.busy), 0);
            check({tag, " p_cnt_hold"}, int'(bus.p_cnt), p);
            check({tag, " d_cnt_hold"}, int'(bus.d_cnt), d);
        end
    endtask

    initial begin
        int rp, rd, rb, rl, rlo, rhi, ndone;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.lo    = '0;
        bus.hi    = '0;

        tbl[0] = '{lo: 0,  hi: 15, p: 6, d: 6, both: 1, lat: 33};
        tbl[1] = '{lo: 2,  hi: 7,  p: 4, d: 2, both: 1, lat: 13};
        tbl[2] = '{lo: 14, hi: 1,  p: 0, d: 2, both: 0, lat: 9};
        tbl[3] = '{lo: 13, hi: 13, p: 1, d: 0, both: 0, lat: 3};

        // Reset state
        repeat (3) tick();
        check("rst a_out", int'(bus.a_out), 0);
        check("rst p_cnt", int'(bus.p_cnt), 0);
        check("rst d_cnt", int'(bus.d_cnt), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        rst_n = 1'b1;
        tick();

        // Directed table; the single-operand entry also pulses start mid-sweep
        for (int i = 0; i < 4; i++) begin
            run_sweep(tbl[i].lo, tbl[i].hi, tbl[i].p, tbl[i].d, tbl[i].both,
                      tbl[i].lat, 1'b0, 1'b0, 0, 0, (i == 3), $sformatf("tbl%0d", i));
            tick();
        end

        // Back-to-back: start sampled in the idle cycle right after done
        run_sweep(0, 15, 6, 6, 1, 33, 1'b0, 1'b1, 2, 7, 1'b0, "b2b_first");
        run_sweep(2, 7, 4, 2, 1, 13, 1'b1, 1'b0, 0, 0, 1'b0, "b2b_second");

        // Abort during SETTLE of operand 5
        bus.lo = WIDTH'(0); bus.hi = WIDTH'(15); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort p_cnt", int'(bus.p_cnt), 2);
        check("abort d_cnt", int'(bus.d_cnt), 2);
        check("abort a_out_hold", int'(bus.a_out), 5);
        ndone = 0;
        repeat (6) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("abort no_done", ndone, 0);

        // start together with abort in IDLE is ignored
        bus.lo = WIDTH'(3); bus.hi = WIDTH'(4);
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort busy", int'(bus.busy), 0);
        check("start_abort p_cnt", int'(bus.p_cnt), 2);
        tick();
        check("start_abort busy_later", int'(bus.busy), 0);
        check("start_abort a_out", int'(bus.a_out), 5);

        // Asynchronous reset mid-sweep
        bus.lo = WIDTH'(0); bus.hi = WIDTH'(15); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        check("pre_rst p_cnt", int'(bus.p_cnt), 1);
        rst_n = 1'b0;
        #1;
        check("midrst a_out", int'(bus.a_out), 0);
        check("midrst p_cnt", int'(bus.p_cnt), 0);
        check("midrst d_cnt", int'(bus.d_cnt), 0);
        check("midrst busy", int'(bus.busy), 0);
        check("midrst done", int'(bus.done), 0);
`ifdef CLASSIFY_BOTH_CNT_EN
        check("midrst both_cnt", int'(bus.both_cnt), 0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst done", int'(bus.done), 0);
        run_sweep(tbl[0].lo, tbl[0].hi, tbl[0].p, tbl[0].d, tbl[0].both,
                  tbl[0].lat, 1'b0, 1'b0, 0, 0, 1'b0, "post_rst_full");

        // Randomized sweeps against the reference model
        for (int i = 0; i < 24; i++) begin
            rlo = int'($urandom_range(0, RANGE - 1));
            rhi = int'($urandom_range(0, RANGE - 1));
            model(rlo, rhi, rp, rd, rb, rl);
            run_sweep(rlo, rhi, rp, rd, rb, rl, 1'b0, 1'b0, 0, 0, 1'b0,
                      $sformatf("rnd%0d_%0d_%0d", i, rlo, rhi));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_classify_sweep_ctrl

// File: doc/classify_sweep_ctrl.md
# classify_sweep_ctrl

Sequencer for the 4-bit combinational operand classifier (operand `a`, flag outputs `p` and `d`). On a start pulse it walks the operand input through an inclusive range `lo..hi`, one operand every two cycles, and accumulates how many operands raised each flag. It sits between control logic and one classifier instance, and owns that instance's operand bus for the duration of a sweep.

## Interface
- `WIDTH`, 4, operand width; must match the classifier input.
- `CNT_W`, `WIDTH+1`, counter width; holds a full-range count of 2^WIDTH.
- `clk` in 1: the only clock; rising-edge.
- `rst_n` in 1: **one clock; reset is asynchronous and active-low.**
- `start` in 1: request a sweep; sampled only in IDLE.
- `abort` in 1: terminate the sweep in progress.
- `lo` in WIDTH: first operand; captured on an accepted start.
- `hi` in WIDTH: last operand, inclusive; captured on an accepted start.
- `a_out` out WIDTH: drives the classifier operand input `a`.
- `p_in` in 1: classifier `p` flag.
- `d_in` in 1: classifier `d` flag.
- `busy` out 1: high while a sweep is active (state != IDLE).
- `done` out 1: one-cycle completion pulse.
- `p_cnt` out CNT_W: number of operands with `p_in`=1.
- `d_cnt` out CNT_W: number of operands with `d_in`=1.
- `both_cnt` out CNT_W: present only under `CLASSIFY_BOTH_CNT_EN`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - With `start`=1 and `abort`=0: `a_out` <= `lo`; capture `hi` into `hi_r`; clear all counters; go to SETTLE.
  - With `abort`=1: `start` is ignored and the block stays in IDLE.
- **SETTLE**: hold `a_out` for one cycle so the classifier output settles; go to SAMPLE.
- **SAMPLE**
  - Add `p_in` to `p_cnt` and `d_in` to `d_cnt`.
  - If `a_out`==`hi_r`: go to DONE.
  - Otherwise: `a_out` <= `a_out`+1, wrapping modulo 2^WIDTH; go to SETTLE.
- **DONE**: `done`=1 for this cycle only; go to IDLE. `abort` has no effect in this state.
- `abort`=1 in SETTLE or SAMPLE:
  - Next state is IDLE; no `done` pulse.
  - Counters keep their partial values; a SAMPLE cycle that coincides with abort still accumulates.
  - `a_out` holds its value.
- Wrap-around: when `lo` > `hi`, the sweep runs `lo`..2^WIDTH-1, then 0..`hi`. Operand count is N = ((`hi`-`lo`) mod 2^WIDTH) + 1.
- `lo`==`hi` gives a single-operand sweep (N=1).
- `start` while `busy`=1 is ignored. Changes on `lo`/`hi` while busy have no effect.
- Counters saturate by construction (N ≤ 2^WIDTH) and need no overflow handling.
- `p_cnt`, `d_cnt` and `a_out` hold their values in IDLE until the next accepted start.

## Timing
- All outputs are registered.
- Reset values: `a_out`=0, `p_cnt`=0, `d_cnt`=0, `both_cnt`=0, `busy`=0, `done`=0, state IDLE.
- `rst_n` low clears everything asynchronously, mid-sweep included. No `done` is issued.
- Start accepted at edge k:
  - `busy`=1 from k.
  - The first operand is sampled at edge k+2.
  - The last operand is sampled at edge k+2N.
  - `done`=1 for the cycle following edge k+2N+1, i.e. 2N+1 cycles after start.
  - `busy` drops at edge k+2N+2.
- Final counts are valid when `done`=1 and remain stable afterwards.
- Back-to-back sweeps: a `start` sampled in the IDLE cycle right after DONE is accepted. Minimum start-to-start spacing is 2N+2 cycles.
- `p_in`/`d_in` are sampled only in SAMPLE; their values in other cycles are don't-care.

## Configuration
- `CLASSIFY_BOTH_CNT_EN` defined:
  - Adds the `both_cnt` output and counter.
  - It increments in SAMPLE when `p_in` && `d_in`, with the same clear/abort/reset rules as the other counters.
- `CLASSIFY_BOTH_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
The bench uses a classifier model with p = operand is prime and d = operand divisible by 3 (0 counts). `CLASSIFY_BOTH_CNT_EN` is defined unless noted.

- Full range, `lo`=0, `hi`=15:
  - `done` exactly 33 cycles after the start edge.
  - Final counts `p_cnt`=6, `d_cnt`=6, `both_cnt`=1.
  - `a_out` visits 0..15 in order.
- Range `lo`=2, `hi`=7:
  - `done` after 13 cycles.
  - Final counts `p_cnt`=4, `d_cnt`=2, `both_cnt`=1.
- Wrap, `lo`=14, `hi`=1:
  - Operand sequence 14, 15, 0, 1.
  - `done` after 9 cycles.
  - Final counts `p_cnt`=0, `d_cnt`=2, `both_cnt`=0.
- Single operand, `lo`=`hi`=13:
  - `done` after 3 cycles.
  - Final counts `p_cnt`=1, `d_cnt`=0.
  - A second `start` pulsed mid-sweep is ignored.
- Abort:
  - Full-range sweep aborted during the SETTLE of operand 5 leaves `p_cnt`=2 and `d_cnt`=2 (operands 0–4 sampled), `busy`=0 next cycle, and no `done` pulse.
  - `start`+`abort` together in IDLE leaves `busy` at 0.
- Reset and build variant:
  - `rst_n` low mid-sweep zeroes all outputs immediately.
  - A sweep started after release behaves as in the full-range case.
  - Rebuilding without the macro gives identical `p_cnt`/`d_cnt`/`done` results.
